rf_host_bridge: RTL and testbench
=================================

Name: rf_host_bridge

Overview:
- Upstream master for a generated register file (RF) with the address/read_en/write_en/write_data/read_data/access_complete/invalid_address port set.
- Accepts byte-addressed host requests on a valid/ready channel and checks alignment and range.
- Issues single-cycle RF strobes, waits for access_complete with a timeout, and returns one buffered response per request on a valid/ready channel.

Parameters:
HOST_ADDR_W, 16, host byte-address width
RF_ADDR_HI, 4, MSB of RF word address; RF address is bits [RF_ADDR_HI:3]
DATA_W, 64, data width (fixed 64, 8-byte words)
TIMEOUT, 16, max cycles to wait for access_complete after the strobe

Ports:
clk  in  1  clock
res_n  in  1  reset, asynchronous, active-low
req_valid  in  1  host request valid
req_ready  out  1  bridge accepts request
req_write  in  1  1=write, 0=read
req_addr  in  HOST_ADDR_W  byte address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  read data (0 for writes/errors)
rsp_status  out  2  0=OK, 1=RF invalid_address, 2=decode error, 3=timeout
address  out  RF_ADDR_HI-2  RF word address
read_en  out  1  RF read strobe
write_en  out  1  RF write strobe
write_data  out  DATA_W  RF write data
read_data  in  DATA_W  RF read data
invalid_address  in  1  RF flags address unmapped
access_complete  in  1  RF access done

Behaviour:
- Reset (res_n low, async): state IDLE; req_ready=0 during reset, 1 after; rsp_valid=0, rsp_data=0, rsp_status=0, address=0, read_en=0, write_en=0, write_data=0; timeout counter=0.
- States: IDLE, STROBE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, register write flag, address, and wdata, then decode:
  - req_addr[2:0]!=0, or any bit above RF_ADDR_HI set -> decode error; go to RESP with status 2 and data 0; no RF strobe ever issued.
  - Otherwise go to STROBE.
- STROBE (exactly 1 cycle): read_en or write_en=1; address=req_addr[RF_ADDR_HI:3]; write_data valid. Next state WAIT; counter cleared.
- WAIT: strobes 0; address/write_data held stable.
  - access_complete=1 -> capture read_data (reads only; writes give 0) and status (1 if invalid_address else 0); go to RESP.
  - Else counter increments; on reaching TIMEOUT -> status 3, data 0, go to RESP.
  - access_complete in the same cycle as the timeout wins (completion reported).
- RESP: rsp_valid=1; rsp_data/rsp_status held stable until rsp_valid&rsp_ready; then IDLE. req_ready=0 throughout.
- Latency (RF completing 1 cycle after strobe, rsp_ready=1): accept at edge N, strobe in cycle N+1, complete sampled at N+2, rsp_valid in cycle N+3, req_ready again N+4. Decode errors: rsp_valid in cycle N+1.
- access_complete outside WAIT (late after timeout) is ignored; no state change.
- One outstanding request max; no pipelining.
- Reset mid-operation: everything returns to reset values immediately; the pending response is lost.
- Counter width $clog2(TIMEOUT+1); no wrap possible.

Decomposition:
- Package rf_host_pkg: state enum, status codes (ST_OK, ST_RF_INVALID, ST_DECODE, ST_TIMEOUT), WORD_LSB=3.
- No sub-module is warranted; one FSM module with an inline timeout counter.

Test Plan:
- Write 0x10, wdata 0x555AAA555AAA555A; RF stub completes 1 cycle after strobe -> exactly one write_en cycle, address=2'b10, write_data matches; rsp status 0, data 0, rsp_valid 3 cycles after acceptance.
- Read 0x08; stub returns read_data 0x000000000000555A -> one read_en cycle, address=2'b01; rsp_data 0x555A, status 0.
- Read 0x0C (misaligned) and read 0x20 (out of range) -> no read_en/write_en; status 2, data 0, rsp_valid the cycle after acceptance.
- Read 0x18; stub asserts access_complete with invalid_address=1 -> status 1, data 0.
- Stub never completes -> status 3 after 16 WAIT cycles. Inject a late access_complete during IDLE -> ignored. Next request processed normally.
- rsp_ready held low 5 cycles during RESP -> rsp_valid/data/status stable, req_ready=0. Assert res_n low during WAIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rf_host_pkg.sv
// Shared types and constants for the host-to-register-file bridge.
package rf_host_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_RF_INVALID = 2'd1;
    localparam logic [1:0] ST_DECODE     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT    = 2'd3;

    // Host addresses are byte addresses; the RF works on 8-byte words.
    localparam int WORD_LSB = 3;

endpackage

// File: rtl/rf_host_bridge.sv
// Bridges a valid/ready host channel onto a generated register file's strobe interface,
// with alignment/range decode, a completion timeout and one buffered response per request.
module rf_host_bridge
    import rf_host_pkg::*;
#(
    parameter int HOST_ADDR_W = 16,
    parameter int RF_ADDR_HI  = 4,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT     = 16
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [HOST_ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [1:0]              rsp_status,
    output logic [RF_ADDR_HI-3:0]   address,
    output logic                    read_en,
    output logic                    write_en,
    output logic [DATA_W-1:0]       write_data,
    input  logic [DATA_W-1:0]       read_data,
    input  logic                    invalid_address,
    input  logic                    access_complete
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [HOST_ADDR_W-1:0] HI_MASK = {HOST_ADDR_W{1'b1}} << (RF_ADDR_HI + 1);

    state_t            state;
    state_t            state_next;
    logic              is_write;
    logic [CNT_W-1:0]  wait_cnt;
    logic              decode_ok;
    logic              timeout_hit;

    assign decode_ok   = (req_addr[WORD_LSB-1:0] == '0) && ((req_addr & HI_MASK) == '0);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is gated by res_n so the host never sees the bridge ready while held in reset.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = res_n;
                if (req_valid && res_n) begin
                    state_next = decode_ok ? S_STROBE : S_RESP;
                end
            end
            S_STROBE: begin
                read_en    = !is_write;
                write_en   = is_write;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (access_complete || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Completion is tested before the timeout so a same-cycle access_complete is reported.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            is_write   <= 1'b0;
            address    <= '0;
            write_data <= '0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        is_write   <= req_write;
                        address    <= req_addr[RF_ADDR_HI:WORD_LSB];
                        write_data <= req_wdata;
                        if (!decode_ok) begin
                            rsp_data   <= '0;
                            rsp_status <= ST_DECODE;
                        end
                    end
                end
                S_STROBE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (access_complete) begin
                        rsp_data   <= (is_write || invalid_address) ? '0 : read_data;
                        rsp_status <= invalid_address ? ST_RF_INVALID : ST_OK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            rsp_data   <= '0;
                            rsp_status <= ST_TIMEOUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_host_bridge.sv
// Self-checking bench for rf_host_bridge: directed scenarios plus randomized requests
// compared against a request-level reference model.
module tb_rf_host_bridge;

    logic        clk;
    logic        res_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [1:0]  address;
    logic        read_en;
    logic        write_en;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        invalid_address;
    logic        access_complete;

    int checks = 0;
    int errors = 0;

    int          obs_rd, obs_wr, obs_lat;
    logic [1:0]  obs_addr;
    logic [63:0] obs_wdata, obs_data;
    logic [1:0]  obs_status;
    bit          obs_unstable, obs_hold_bad, obs_rdy_after;

    int          exp_rd, exp_wr, exp_lat;
    logic [1:0]  exp_addr;
    logic [63:0] exp_data;
    logic [1:0]  exp_status;

    rf_host_bridge dut (
        .clk             (clk),
        .res_n           (res_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .address         (address),
        .read_en         (read_en),
        .write_en        (write_en),
        .write_data      (write_data),
        .read_data       (read_data),
        .invalid_address (invalid_address),
        .access_complete (access_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request-level model: delay is how many cycles after the strobe the RF completes (0 = never).
    // Latency counts cycles from acceptance to the first cycle with rsp_valid.
    task automatic model(input bit wr, input int addr, input int delay, input bit inv,
                         input logic [63:0] rd);
        if ((addr % 8) != 0 || addr >= 32) begin
            exp_status = 2'd2; exp_data = '0; exp_lat = 1;
            exp_rd = 0; exp_wr = 0; exp_addr = '0;
        end else begin
            exp_rd   = wr ? 0 : 1;
            exp_wr   = wr ? 1 : 0;
            exp_addr = 2'(addr / 8);
            if (delay >= 1 && delay <= 16) begin
                exp_lat    = 2 + delay;
                exp_status = inv ? 2'd1 : 2'd0;
                exp_data   = (wr || inv) ? 64'd0 : rd;
            end else begin
                exp_lat = 2 + 16; exp_status = 2'd3; exp_data = '0;
            end
        end
    endtask

    // Drives one request, plays the RF stub, and records what the bridge did.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                           input int delay, input bit inv, input logic [63:0] rd, input int hold);
        int strobe_c;
        int c;
        int guard;
        obs_rd = 0; obs_wr = 0; obs_addr = '0; obs_wdata = '0; obs_lat = -1;
        obs_data = '0; obs_status = '0; obs_unstable = 0; obs_hold_bad = 0; obs_rdy_after = 0;
        strobe_c = -1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = {$urandom, $urandom};
        c = 1;
        while (c <= 40 && obs_lat < 0) begin
            if (read_en === 1'b1) obs_rd++;
            if (write_en === 1'b1) obs_wr++;
            if ((read_en === 1'b1 || write_en === 1'b1) && strobe_c < 0) begin
                strobe_c = c; obs_addr = address; obs_wdata = write_data;
            end else if (strobe_c >= 0 && rsp_valid !== 1'b1 &&
                         (address !== obs_addr || write_data !== obs_wdata)) begin
                obs_unstable = 1;
            end
            if (rsp_valid === 1'b1) begin
                obs_lat = c; obs_data = rsp_data; obs_status = rsp_status;
                access_complete = 1'b0;
            end else begin
                if (strobe_c >= 0 && delay > 0 && c == strobe_c + delay) begin
                    access_complete = 1'b1; invalid_address = inv; read_data = rd;
                end else begin
                    access_complete = 1'b0; invalid_address = 1'($urandom);
                    read_data = {$urandom, $urandom};
                end
                @(negedge clk);
                c++;
            end
        end
        access_complete = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_status !== obs_status ||
                req_ready !== 1'b0) obs_hold_bad = 1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        obs_rdy_after = (req_ready === 1'b1 && rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({req_ready, rsp_valid, read_en, write_en, address, rsp_status} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {req_ready, rsp_valid, read_en, write_en, address, rsp_status});
        end
        checks++;
        if ({write_data, rsp_data} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got wd=%h rd=%h expected 0", write_data, rsp_data);
        end
        @(negedge clk);
        res_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write();
        model(1'b1, 'h10, 1, 1'b0, 64'd0);
        run_txn(1'b1, 16'h0010, 64'h555AAA555AAA555A, 1, 1'b0, 64'hDEADBEEFCAFEF00D, 0);
        checks++;
        if (obs_wr !== exp_wr || obs_rd !== exp_rd) begin
            errors++; $display("[TB] FAIL wr_strobes: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                               obs_rd, obs_wr, exp_rd, exp_wr);
        end
        checks++;
        if (obs_addr !== exp_addr || obs_wdata !== 64'h555AAA555AAA555A) begin
            errors++; $display("[TB] FAIL wr_addr_data: got %b/%h expected %b/555aaa555aaa555a",
                               obs_addr, obs_wdata, exp_addr);
        end
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
            errors++; $display("[TB] FAIL wr_rsp: got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                               obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
        end
        checks++;
        if (obs_rdy_after !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_ready_after: got %b expected 1", obs_rdy_after);
        end
    endtask

    task automatic test_read();
        model(1'b0, 'h08, 1, 1'b0, 64'h555A);
        run_txn(1'b0, 16'h0008, 64'h0123456789ABCDEF, 1, 1'b0, 64'h555A, 0);
        checks++;
        if (obs_rd !== exp_rd || obs_wr !== exp_wr || obs_addr !== exp_addr) begin
            errors++; $display("[TB] FAIL rd_strobe: got rd=%0d wr=%0d a=%b expected rd=%0d wr=%0d a=%b",
                               obs_rd, obs_wr, obs_addr, exp_rd, exp_wr, exp_addr);
        end
        checks++;
        if (obs_data !== exp_data || obs_status !== exp_status || obs_lat !== exp_lat) begin
            errors++; $display("[TB] FAIL rd_rsp: got d=%h st=%0d lat=%0d expected d=%h st=%0d lat=%0d",
                               obs_data, obs_status, obs_lat, exp_data, exp_status, exp_lat);
        end
    endtask

    task automatic test_decode_error();
        logic [15:0] addrs [2];
        addrs[0] = 16'h000C;
        addrs[1] = 16'h0020;
        for (int i = 0; i < 2; i++) begin
            model(1'b0, int'(addrs[i]), 1, 1'b0, 64'hFFFF);
            run_txn(1'b0, addrs[i], 64'd0, 1, 1'b0, 64'hFFFF, 0);
            checks++;
            if (obs_rd !== 0 || obs_wr !== 0) begin
                errors++; $display("[TB] FAIL dec_no_strobe: addr=%h got rd=%0d wr=%0d expected 0/0",
                                   addrs[i], obs_rd, obs_wr);
            end
            checks++;
            if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
                errors++; $display("[TB] FAIL dec_rsp: addr=%h got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                                   addrs[i], obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
            end
        end
    endtask

    task automatic test_rf_invalid();
        model(1'b0, 'h18, 2, 1'b1, 64'hA5A5A5A5A5A5A5A5);
        run_txn(1'b0, 16'h0018, 64'd0, 2, 1'b1, 64'hA5A5A5A5A5A5A5A5, 0);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
            errors++; $display("[TB] FAIL inv_rsp: got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                               obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
        end
    endtask

    task automatic test_timeout();
        bit late_bad;
        logic [63:0] rd;
        model(1'b0, 'h00, 0, 1'b0, 64'd0);
        run_txn(1'b0, 16'h0000, 64'd0, 0, 1'b0, 64'h1111, 0);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
            errors++; $display("[TB] FAIL to_rsp: got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                               obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
        end
        late_bad = 0;
        access_complete = 1'b1; invalid_address = 1'b1; read_data = 64'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || read_en !== 1'b0 || write_en !== 1'b0)
                late_bad = 1;
        end
        access_complete = 1'b0;
        checks++;
        if (late_bad) begin
            errors++; $display("[TB] FAIL late_complete: got reaction=1 expected 0");
        end
        rd = {$urandom, $urandom};
        model(1'b0, 'h08, 3, 1'b0, rd);
        run_txn(1'b0, 16'h0008, 64'd0, 3, 1'b0, rd, 0);
        checks++;
        if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
            errors++; $display("[TB] FAIL after_to_rsp: got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                               obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd;
        rd = {$urandom, $urandom} | 64'h1;
        model(1'b0, 'h18, 2, 1'b0, rd);
        run_txn(1'b0, 16'h0018, 64'd0, 2, 1'b0, rd, 5);
        checks++;
        if (obs_hold_bad) begin
            errors++; $display("[TB] FAIL bp_stable: got unstable=1 expected 0");
        end
        checks++;
        if (obs_data !== exp_data || obs_status !== exp_status || obs_rdy_after !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_rsp: got d=%h st=%0d rdy=%b expected d=%h st=%0d rdy=1",
                               obs_data, obs_status, obs_rdy_after, exp_data, exp_status);
        end
    endtask

    task automatic test_random();
        bit          wr, inv;
        int          sel, delay, hold;
        logic [15:0] a;
        logic [63:0] rd, wd;
        for (int i = 0; i < 24; i++) begin
            wr  = 1'($urandom);
            sel = $urandom_range(0, 5);
            if (sel <= 3)      a = 16'($urandom_range(0, 3) * 8);
            else if (sel == 4) a = 16'($urandom_range(0, 3) * 8 + $urandom_range(1, 7));
            else               a = 16'($urandom_range(32, 65535));
            delay = $urandom_range(0, 18);
            inv   = ($urandom_range(0, 3) == 0);
            hold  = $urandom_range(0, 2);
            rd    = {$urandom, $urandom};
            wd    = {$urandom, $urandom};
            model(wr, int'(a), delay, inv, rd);
            run_txn(wr, a, wd, delay, inv, rd, hold);
            checks++;
            if (obs_status !== exp_status || obs_data !== exp_data || obs_lat !== exp_lat) begin
                errors++; $display("[TB] FAIL rnd_rsp[%0d]: a=%h got st=%0d d=%h lat=%0d expected st=%0d d=%h lat=%0d",
                                   i, a, obs_status, obs_data, obs_lat, exp_status, exp_data, exp_lat);
            end
            checks++;
            if (obs_rd !== exp_rd || obs_wr !== exp_wr ||
                ((exp_rd + exp_wr) != 0 && obs_addr !== exp_addr) ||
                (exp_wr != 0 && obs_wdata !== wd)) begin
                errors++; $display("[TB] FAIL rnd_strobe[%0d]: got rd=%0d wr=%0d a=%b wd=%h expected rd=%0d wr=%0d a=%b wd=%h",
                                   i, obs_rd, obs_wr, obs_addr, obs_wdata, exp_rd, exp_wr, exp_addr, wd);
            end
            checks++;
            if (obs_unstable || obs_hold_bad || !obs_rdy_after) begin
                errors++; $display("[TB] FAIL rnd_hold[%0d]: got unstable=%b hold_bad=%b rdy=%b expected 0/0/1",
                                   i, obs_unstable, obs_hold_bad, obs_rdy_after);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit lost_bad;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0008; req_wdata = 64'hFEEDFACE12345678;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        res_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, read_en, write_en, address, rsp_status} !== 8'd0 ||
            {write_data, rsp_data} !== 128'd0) begin
            errors++; $display("[TB] FAIL mid_reset: got ctl=%b wd=%h rd=%h expected all 0",
                               {req_ready, rsp_valid, read_en, write_en, address, rsp_status},
                               write_data, rsp_data);
        end
        @(negedge clk);
        res_n = 1'b1;
        lost_bad = 0;
        access_complete = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) lost_bad = 1;
        end
        access_complete = 1'b0;
        checks++;
        if (lost_bad) begin
            errors++; $display("[TB] FAIL mid_reset_lost: got pending response expected none");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; read_data = '0; invalid_address = 1'b0; access_complete = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_write();
        test_read();
        test_decode_error();
        test_rf_invalid();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
